// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 50;
    localparam int DATA_W           = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        PUSH   = 3'd5,
        BREAK  = 3'd6
    } rx_state_e;

    // Even parity: data bits and parity bit together must XOR to zero.
    function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
        return (^{d, p}) == 1'b0;
    endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// RX FIFO side of the UART receiver: push strobe, data and status pulses.
// parity_err is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_controller_if;
    import uart_pkg::*;

    logic              full;
    logic [DATA_W-1:0] data_out;
    logic              write_en;
    logic              frame_err;
    logic              overrun;
    logic              busy;
`ifdef UART_RX_PARITY_EN
    logic              parity_err;

    modport master (input full, output data_out, write_en, frame_err, overrun, busy, parity_err);
    modport slave  (output full, input data_out, write_en, frame_err, overrun, busy, parity_err);
`else
    modport master (input full, output data_out, write_en, frame_err, overrun, busy);
    modport slave  (output full, input data_out, write_en, frame_err, overrun, busy);
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input plus a falling-edge detector.
// All flops reset to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_b,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_d;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: mid-bit sampling of 8N1 frames (8E1 with UART_RX_PARITY_EN),
// pushing good bytes to the RX FIFO and flagging framing errors and overruns.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 rx,
    uart_rx_controller_if.master fifo
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    rx_state_e         state;
    logic [CW-1:0]     cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              rx_s;
    logic              rx_fall;
`ifdef UART_RX_PARITY_EN
    logic              par_bit;
`endif

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset_b(reset_b),
        .rx     (rx),
        .rx_s   (rx_s),
        .fall   (rx_fall)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            fifo.data_out  <= '0;
            fifo.write_en  <= 1'b0;
            fifo.frame_err <= 1'b0;
            fifo.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit        <= 1'b0;
            fifo.parity_err <= 1'b0;
`endif
        end else begin
            fifo.write_en  <= 1'b0;
            fifo.frame_err <= 1'b0;
            fifo.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            fifo.parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_fall) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                // Sampling mid-stop-bit lets IDLE catch a start edge right after it.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= PUSH;
                        end else begin
                            fifo.frame_err <= 1'b1;
                            state          <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PUSH: begin
                    state <= IDLE;
`ifdef UART_RX_PARITY_EN
                    if (!parity_ok(shift, par_bit)) begin
                        fifo.parity_err <= 1'b1;
                    end else
`endif
                    if (fifo.full) begin
                        fifo.overrun <= 1'b1;
                    end else begin
                        fifo.write_en <= 1'b1;
                        fifo.data_out <= shift;
                    end
                end
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo.busy = (state != IDLE);

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- UART receive path for the 5.76 MHz acoustics FPGA domain; counterpart of the TX controller.
- Samples the serial line at mid-bit, assembles 8N1 frames LSB first, and pushes each good byte into the RX FIFO.
- Flags framing errors and FIFO overruns.
- Integrated datapath (synchronizer, baud counter, shift register); no external counter block.

Parameters:
- CLKS_PER_BIT, 50, clk cycles per bit (5.76 MHz / 115200 baud); must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2, start-bit mid-point offset.

Ports:
- clk  in  1  system clock, 5.76 MHz
- reset_b  in  1  asynchronous, active-low reset
- rx  in  1  asynchronous serial input; idle high
- full  in  1  RX FIFO full
- data_out  out  8  received byte; valid while write_en = 1
- write_en  out  1  one-cycle FIFO push strobe
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: good byte dropped because full = 1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: outputs 0, synchronizer flops 1, state IDLE, counters 0. Reset mid-frame aborts immediately; no partial push.
- rx passes through a 2-flop synchronizer, rx_s. A falling edge means the previous rx_s = 1 and the current rx_s = 0.
- States and transitions:
  - IDLE: baud counter held at 0. rx_s falling edge → START.
  - START: count to HALF_BIT-1, then sample rx_s. If 0 → DATA with counter = 0 and bit index = 0. If 1 (glitch) → IDLE, no flags.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index]. The sample is LSB first. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s. If 1 → PUSH. If 0 → pulse frame_err, → BREAK.
  - PUSH (one cycle): if full = 0, write_en = 1 and data_out = shift. If full = 1, overrun = 1, write_en = 0, byte discarded. → IDLE.
  - BREAK: wait for rx_s = 1, then → IDLE. A held-low line or break yields exactly one frame_err, with no re-trigger until the line returns high.
  - Unused encodings → IDLE, all strobes 0.
- Timing:
  - Stop-bit sample occurs HALF_BIT + 9·CLKS_PER_BIT cycles after the synchronized falling edge.
  - write_en asserts on the next cycle.
  - Total rx-pin-to-write_en latency ≈ 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving immediately after the stop bit is caught. Minimum supported gap is 0 idle bits.
- data_out holds its last value between pushes. write_en, frame_err and overrun are mutually exclusive.
- full is sampled only in PUSH.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP: one extra bit sampled at mid-bit.
  - Adds output parity_err (1-bit, one-cycle pulse).
  - The frame is 8E1. If the data bits XOR the parity bit ≠ 0, pulse parity_err in PUSH instead of write_en, and drop the byte.
  - Priority when several errors apply: frame_err > parity_err > overrun.
- Undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP, PUSH, BREAK), 3-bit;
  - the default CLKS_PER_BIT value;
  - the frame data width (8).
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detector, reset to 1.
- The FSM, baud counter and shift register stay in uart_rx_controller.

Test Plan:
- Send 0xA5 as 8N1 at 50 clk/bit with full = 0 → one write_en pulse with data_out = 0xA5; busy falls after stop. Repeat with 0x00 and 0xFF.
- 10-cycle low glitch on idle rx → no write_en, frame_err or overrun; state returns to IDLE.
- Send 0x3C with stop bit forced 0, then hold rx low for 20 bit times → exactly one frame_err, no write_en. After rx goes high, 0x5A is received correctly.
- Send 0x81 with full = 1 → overrun pulse, no write_en. Next frame 0x18 with full = 0 → write_en with data_out = 0x18.
- Send 0x11, 0x22, 0x33 back-to-back with zero idle gap → three write_en pulses in order, spaced 10·CLKS_PER_BIT ±1 cycles.
- Assert reset_b low during bit 4 of a frame → outputs 0 asynchronously, no push. After release with rx high, the next frame 0x7E is received.
